// File: rtl/lcd_cmd_engine.sv
// Hardware-timed HD44780 bus driver: one GO edge in the LCD register launches a full
// setup / enable / hold / execution-wait transfer, with a one-deep request queue.
module lcd_cmd_engine #(
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 25,
    parameter int T_HOLD      = 2,
    parameter int T_WAIT      = 2000,
    parameter int T_WAIT_LONG = 82000,
    parameter int CW = $clog2(
        ((T_WAIT_LONG > T_WAIT) ? T_WAIT_LONG : T_WAIT) >
        ((T_PULSE > ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)) ? T_PULSE : ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD))
        ? ((T_WAIT_LONG > T_WAIT) ? T_WAIT_LONG : T_WAIT)
        : ((T_PULSE > ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)) ? T_PULSE : ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD))
    ) + 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lcd_word,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_busy,
    output logic        o_lcd_ovf
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam logic [CW-1:0] LD_SETUP     = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE     = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD      = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_WAIT      = CW'(T_WAIT - 1);
    localparam logic [CW-1:0] LD_WAIT_LONG = CW'(T_WAIT_LONG - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          go_q;
    logic          pend_valid;
    logic          pend_rs;
    logic [7:0]    pend_data;

    logic          on_in;
    logic          go_in;
    logic          rs_in;
    logic [7:0]    data_in;
    logic          req;
    logic          phase_done;
    logic          wait_exit;
    logic          queue_req;
    logic          is_long;
    logic          unused_word_bits;

    assign on_in   = i_lcd_word[31];
    assign go_in   = i_lcd_word[10];
    assign rs_in   = i_lcd_word[9];
    assign data_in = i_lcd_word[7:0];
    assign unused_word_bits = ^{i_lcd_word[30:11], i_lcd_word[8]};

    assign req        = go_in & ~go_q & on_in;
    assign phase_done = (cnt == '0);
    assign wait_exit  = (state == ST_WAIT) & phase_done;
    // Requests on the WAIT exit edge are handled by the exit logic itself, so the
    // slot freed on that edge can take them instead of flagging an overrun.
    assign queue_req  = req & (state != ST_IDLE) & ~wait_exit;

    // Clear and return-home need the long execution wait; judged on the command on the bus.
    assign is_long = ~o_lcd_rs & ((o_lcd_data == 8'h01) | (o_lcd_data == 8'h02) | (o_lcd_data == 8'h03));

    assign o_lcd_rw = 1'b0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            go_q       <= 1'b0;
            pend_valid <= 1'b0;
            pend_rs    <= 1'b0;
            pend_data  <= 8'h00;
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_lcd_busy <= 1'b0;
            o_lcd_ovf  <= 1'b0;
        end else begin
            go_q     <= go_in;
            o_lcd_on <= on_in;

            if (!on_in) begin
                // Power-off aborts everything except the bus values and the sticky overrun.
                state      <= ST_IDLE;
                cnt        <= '0;
                o_lcd_en   <= 1'b0;
                pend_valid <= 1'b0;
                o_lcd_busy <= 1'b0;
            end else begin
                if (queue_req) begin
                    if (!pend_valid) begin
                        pend_valid <= 1'b1;
                        pend_rs    <= rs_in;
                        pend_data  <= data_in;
                    end else begin
                        o_lcd_ovf <= 1'b1;
                    end
                end

                case (state)
                    ST_IDLE: begin
                        if (req) begin
                            state      <= ST_SETUP;
                            cnt        <= LD_SETUP;
                            o_lcd_rs   <= rs_in;
                            o_lcd_data <= data_in;
                            o_lcd_busy <= 1'b1;
                        end
                    end
                    ST_SETUP: begin
                        if (phase_done) begin
                            state    <= ST_PULSE;
                            cnt      <= LD_PULSE;
                            o_lcd_en <= 1'b1;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    ST_PULSE: begin
                        if (phase_done) begin
                            state    <= ST_HOLD;
                            cnt      <= LD_HOLD;
                            o_lcd_en <= 1'b0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (phase_done) begin
                            state <= ST_WAIT;
                            cnt   <= is_long ? LD_WAIT_LONG : LD_WAIT;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    ST_WAIT: begin
                        if (phase_done) begin
                            if (pend_valid) begin
                                // Queued transfer starts immediately; a same-edge request refills the slot.
                                state      <= ST_SETUP;
                                cnt        <= LD_SETUP;
                                o_lcd_rs   <= pend_rs;
                                o_lcd_data <= pend_data;
                                pend_valid <= req;
                                if (req) begin
                                    pend_rs   <= rs_in;
                                    pend_data <= data_in;
                                end
                            end else if (req) begin
                                state      <= ST_SETUP;
                                cnt        <= LD_SETUP;
                                o_lcd_rs   <= rs_in;
                                o_lcd_data <= data_in;
                            end else begin
                                state      <= ST_IDLE;
                                o_lcd_busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        o_lcd_en   <= 1'b0;
                        o_lcd_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
